// File: rtl/cache_ctrl_nway.sv
// cache_ctrl_nway: N-way set-associative cache controller.
//
// This controller sits between the CPU slave bus (s_cyc/s_stb) and the
// memory master bus (m_cyc/m_stb/m_ack/m_retry). It drives the load and
// select lines of an external tag/data/valid/dirty/PLRU datapath. It uses
// tree-PLRU victim selection, write-allocate on a write miss, a registered
// victim way and a one-cycle retry back-off.
//
// Parameters:
//   WAYS   associativity (power of two, 2..8)
//   WIDX   way index width, derived from WAYS (do not override)
//   SEL_W  memory byte-select width
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   s_cyc, s_stb          CPU request qualifiers
//   mem_read, mem_write   CPU request type (both set is treated as a read)
//   mem_resp              CPU acknowledge, one cycle per request
//   m_cyc, m_stb          memory bus cycle/strobe
//   physical_mem_write    memory write enable
//   m_sel                 byte selects, all-ones while m_stb is high
//   m_ack, m_retry        memory acknowledge / retry
//   hit, valid, dirty     per-way status of the current set
//   plru_in / plru_out    tree-PLRU bits in / updated bits out
//   load_plru             PLRU write enable
//   way_sel               datapath output-mux way select
//   load_data/tag/valid/dirty  one-hot array write enables
//   valid_in, dirty_in    values written with load_valid/load_dirty
//   cache_in_sel          0 = fill data from memory, 1 = CPU write data
//   mem_address_sel       0 = CPU address, 1 = victim tag + set address
//
// Optional feature (macro CACHE_PERF_CNT_EN): when defined, this adds the
// hit_count and miss_count ports. These are saturating 32-bit counters.
module cache_ctrl_nway #(
  parameter int WAYS  = 4,
  parameter int WIDX  = $clog2(WAYS),
  parameter int SEL_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_cyc,
  input  logic             s_stb,
  input  logic             mem_read,
  input  logic             mem_write,
  output logic             mem_resp,
  output logic             m_cyc,
  output logic             m_stb,
  output logic             physical_mem_write,
  output logic [SEL_W-1:0] m_sel,
  input  logic             m_ack,
  input  logic             m_retry,
  input  logic [WAYS-1:0]  hit,
  input  logic [WAYS-1:0]  valid,
  input  logic [WAYS-1:0]  dirty,
  input  logic [WAYS-2:0]  plru_in,
  output logic [WAYS-2:0]  plru_out,
  output logic             load_plru,
  output logic [WIDX-1:0]  way_sel,
  output logic [WAYS-1:0]  load_data,
  output logic [WAYS-1:0]  load_tag,
  output logic [WAYS-1:0]  load_valid,
  output logic [WAYS-1:0]  load_dirty,
  output logic             valid_in,
  output logic             dirty_in,
  output logic             cache_in_sel,
  output logic             mem_address_sel
`ifdef CACHE_PERF_CNT_EN
  ,
  output logic [31:0]      hit_count,
  output logic [31:0]      miss_count
`endif
);

  typedef enum logic [1:0] {
    COMPARE   = 2'd0,
    WRITEBACK = 2'd1,
    FILL      = 2'd2,
    BACKOFF   = 2'd3
  } state_t;

  state_t          state, next_state;
  logic [WIDX-1:0] victim_q, victim_d;
  // BACKOFF return target: 0 = WRITEBACK, 1 = FILL
  logic            ret_fill, ret_fill_d;

  logic            req;
  logic            is_write;
  logic            any_hit;
  logic [WIDX-1:0] hit_way;
  logic            inv_found;
  logic [WIDX-1:0] inv_way;
  logic [WIDX-1:0] plru_victim;
  logic            walk_bit;
  logic [WIDX-1:0] victim;
  logic            victim_dirty;
  logic [WAYS-1:0] victim_oh;
  logic [WAYS-2:0] plru_hit;

  assign req      = s_cyc & s_stb & (mem_read | mem_write);
  assign is_write = mem_write & ~mem_read;
  assign any_hit  = |hit;

  always_comb begin : hit_encode
    hit_way = '0;
    for (int unsigned i = 0; i < WAYS; i++) begin
      if (hit[i]) hit_way = WIDX'(i);
    end
  end

  always_comb begin : first_invalid
    inv_found = 1'b0;
    inv_way   = '0;
    for (int unsigned i = 0; i < WAYS; i++) begin
      if (!valid[i] && !inv_found) begin
        inv_found = 1'b1;
        inv_way   = WIDX'(i);
      end
    end
  end

  // Root-to-leaf walk, one tree level per iteration. The path bits gathered
  // so far index the node within the level: node = (2^lvl - 1) + path.
  always_comb begin : plru_walk
    plru_victim = '0;
    walk_bit    = 1'b0;
    for (int unsigned lvl = 0; lvl < WIDX; lvl++) begin
      walk_bit = 1'b0;
      for (int unsigned j = 0; j < WAYS - 1; j++) begin
        if (j == ((32'd1 << lvl) - 32'd1 + {{(32-WIDX){1'b0}}, plru_victim}))
          walk_bit = plru_in[j];
      end
      plru_victim = WIDX'({plru_victim, walk_bit});
    end
  end

  // Each node on the hit way's path is pointed at the sibling subtree.
  // At level lvl, the node is (2^lvl - 1) + (way >> (WIDX - lvl)), and the
  // way's direction is bit (WIDX-1-lvl) of the way index.
  always_comb begin : plru_touch
    plru_hit = plru_in;
    for (int unsigned lvl = 0; lvl < WIDX; lvl++) begin
      for (int unsigned j = 0; j < WAYS - 1; j++) begin
        if (j == ((32'd1 << lvl) - 32'd1 +
                  ({{(32-WIDX){1'b0}}, hit_way} >> (WIDX - lvl))))
          plru_hit[j] = ~hit_way[WIDX-1-lvl];
      end
    end
  end

  assign victim = inv_found ? inv_way : plru_victim;

  always_comb begin : victim_status
    victim_dirty = 1'b0;
    for (int unsigned i = 0; i < WAYS; i++) begin
      if (victim == WIDX'(i)) victim_dirty = valid[i] & dirty[i];
    end
  end

  always_comb begin : victim_decode
    victim_oh = '0;
    for (int unsigned i = 0; i < WAYS; i++) begin
      victim_oh[i] = (victim_q == WIDX'(i));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= COMPARE;
      victim_q <= '0;
      ret_fill <= 1'b0;
    end else begin
      state    <= next_state;
      victim_q <= victim_d;
      ret_fill <= ret_fill_d;
    end
  end

  always_comb begin : fsm_comb
    next_state         = state;
    victim_d           = victim_q;
    ret_fill_d         = ret_fill;
    mem_resp           = 1'b0;
    m_cyc              = 1'b0;
    m_stb              = 1'b0;
    physical_mem_write = 1'b0;
    plru_out           = '0;
    load_plru          = 1'b0;
    way_sel            = '0;
    load_data          = '0;
    load_tag           = '0;
    load_valid         = '0;
    load_dirty         = '0;
    valid_in           = 1'b0;
    dirty_in           = 1'b0;
    cache_in_sel       = 1'b0;
    mem_address_sel    = 1'b0;

    case (state)
      COMPARE: begin
        if (req) begin
          if (any_hit) begin
            mem_resp  = 1'b1;
            way_sel   = hit_way;
            load_plru = 1'b1;
            plru_out  = plru_hit;
            if (is_write) begin
              load_data    = hit;
              cache_in_sel = 1'b1;
              load_dirty   = hit;
              dirty_in     = 1'b1;
            end
          end else begin
            victim_d   = victim;
            next_state = victim_dirty ? WRITEBACK : FILL;
          end
        end
      end

      WRITEBACK: begin
        way_sel            = victim_q;
        mem_address_sel    = 1'b1;
        physical_mem_write = 1'b1;
        m_cyc              = 1'b1;
        m_stb              = 1'b1;
        if (m_retry) begin
          ret_fill_d = 1'b0;
          next_state = BACKOFF;
        end else if (m_ack) begin
          load_dirty = victim_oh;
          next_state = FILL;
        end
      end

      FILL: begin
        way_sel = victim_q;
        m_cyc   = 1'b1;
        m_stb   = 1'b1;
        if (m_retry) begin
          ret_fill_d = 1'b1;
          next_state = BACKOFF;
        end else if (m_ack) begin
          load_data  = victim_oh;
          load_tag   = victim_oh;
          load_valid = victim_oh;
          valid_in   = 1'b1;
          next_state = COMPARE;
        end
      end

      BACKOFF: begin
        next_state = ret_fill ? FILL : WRITEBACK;
      end

      default: next_state = COMPARE;
    endcase
  end

  assign m_sel = m_stb ? '1 : '0;

`ifdef CACHE_PERF_CNT_EN
  logic hit_evt, miss_evt;

  assign hit_evt  = mem_resp;
  assign miss_evt = (state == COMPARE) & req & ~any_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (hit_evt && (hit_count != '1))
        hit_count <= hit_count + 32'd1;
      if (miss_evt && (miss_count != '1))
        miss_count <= miss_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cache_ctrl_nway.sv
// tb_cache_ctrl_nway: scoreboard bench for cache_ctrl_nway with WAYS=4.
// It models the external datapath: the hit vector becomes one-hot on the
// filled way once a fill completes. It also models a memory slave that
// acknowledges every strobe and can be told to retry the first N strobes.
module tb_cache_ctrl_nway;
  localparam int WAYS  = 4;
  localparam int WIDX  = 2;
  localparam int SEL_W = 16;

  logic             clk;
  logic             rst_n;
  logic             s_cyc, s_stb, mem_read, mem_write;
  logic             mem_resp, m_cyc, m_stb, physical_mem_write;
  logic [SEL_W-1:0] m_sel;
  logic             m_ack, m_retry;
  logic [WAYS-1:0]  hit, valid, dirty;
  logic [WAYS-2:0]  plru_in, plru_out;
  logic             load_plru;
  logic [WIDX-1:0]  way_sel;
  logic [WAYS-1:0]  load_data, load_tag, load_valid, load_dirty;
  logic             valid_in, dirty_in, cache_in_sel, mem_address_sel;
`ifdef CACHE_PERF_CNT_EN
  logic [31:0]      hit_count, miss_count;
`endif

  cache_ctrl_nway #(.WAYS(WAYS), .SEL_W(SEL_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_cyc(s_cyc), .s_stb(s_stb), .mem_read(mem_read), .mem_write(mem_write),
    .mem_resp(mem_resp), .m_cyc(m_cyc), .m_stb(m_stb),
    .physical_mem_write(physical_mem_write), .m_sel(m_sel),
    .m_ack(m_ack), .m_retry(m_retry),
    .hit(hit), .valid(valid), .dirty(dirty),
    .plru_in(plru_in), .plru_out(plru_out), .load_plru(load_plru),
    .way_sel(way_sel),
    .load_data(load_data), .load_tag(load_tag),
    .load_valid(load_valid), .load_dirty(load_dirty),
    .valid_in(valid_in), .dirty_in(dirty_in),
    .cache_in_sel(cache_in_sel), .mem_address_sel(mem_address_sel)
`ifdef CACHE_PERF_CNT_EN
    , .hit_count(hit_count), .miss_count(miss_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int exp_hits   = 0;
  int exp_misses = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  typedef struct {
    int             lat;
    int             way;
    logic [WAYS-2:0] plru;
    logic           wr;
  } exp_t;

  exp_t sb[$];

  function automatic logic [WAYS-1:0] oh(input int w);
    logic [WAYS-1:0] r;
    r = '0;
    r[w] = 1'b1;
    return r;
  endfunction

  // Reference PLRU: a pointer walk down the tree, and a leaf-to-root update.
  function automatic int ref_victim(input logic [WAYS-2:0] p);
    int n;
    n = 0;
    while (n < WAYS - 1) n = 2 * n + 1 + (p[n] ? 1 : 0);
    return n - (WAYS - 1);
  endfunction

  function automatic logic [WAYS-2:0] ref_touch(input logic [WAYS-2:0] p, input int w);
    int n;
    int par;
    logic [WAYS-2:0] r;
    r = p;
    n = w + WAYS - 1;
    while (n > 0) begin
      par = (n - 1) / 2;
      r[par] = (n == 2 * par + 1);
      n = par;
    end
    return r;
  endfunction

  // Call on a falling edge. hw < 0 means a miss on entry.
  task automatic run_txn(input logic [WAYS-1:0] v, input logic [WAYS-1:0] d,
                         input logic [WAYS-2:0] p, input int hw,
                         input logic rd, input logic wr, input int retries,
                         input string name);
    exp_t e;
    exp_t x;
    int   vic;
    logic wb;
    int   cyc;
    int   retry_left;
    logic got_resp, saw_wb, prev_retry, wr_eff;

    wr_eff = wr & ~rd;
    wb = 1'b0;
    if (hw >= 0) begin
      e.way = hw;
      e.lat = 1;
    end else begin
      vic = -1;
      for (int i = WAYS - 1; i >= 0; i--) if (!v[i]) vic = i;
      if (vic < 0) vic = ref_victim(p);
      wb = v[vic] & d[vic];
      e.way = vic;
      e.lat = 3 + (wb ? 1 : 0) + 2 * retries;
      exp_misses++;
    end
    e.plru = ref_touch(p, e.way);
    e.wr   = wr_eff;
    exp_hits++;
    sb.push_back(e);

    valid = v; dirty = d; plru_in = p;
    hit = (hw >= 0) ? oh(hw) : '0;
    s_cyc = 1'b1; s_stb = 1'b1; mem_read = rd; mem_write = wr;
    retry_left = retries;
    got_resp = 1'b0; saw_wb = 1'b0; prev_retry = 1'b0; cyc = 0;

    while (!got_resp && cyc < 40) begin
      m_ack   = m_stb;
      m_retry = m_stb && (retry_left > 0);
      #1;
      cyc++;
      if (prev_retry) begin
        check({name, "_backoff_stb"}, 32'(m_stb), 32'd0);
        check({name, "_backoff_cyc"}, 32'(m_cyc), 32'd0);
      end
      prev_retry = m_retry;
      if (m_retry) begin
        retry_left--;
        check({name, "_retry_noload"},
              32'(load_data | load_tag | load_valid | load_dirty), 32'd0);
      end else if (m_stb && m_ack && physical_mem_write) begin
        saw_wb = 1'b1;
        check({name, "_wb_sel"},   32'(m_sel), 32'hFFFF);
        check({name, "_wb_addr"},  32'(mem_address_sel), 32'd1);
        check({name, "_wb_way"},   32'(way_sel), 32'(e.way));
        check({name, "_wb_ldirty"}, 32'(load_dirty), 32'(oh(e.way)));
        check({name, "_wb_din"},   32'(dirty_in), 32'd0);
      end else if (m_stb && m_ack) begin
        check({name, "_fill_lvalid"}, 32'(load_valid), 32'(oh(e.way)));
        check({name, "_fill_ltag"},   32'(load_tag), 32'(oh(e.way)));
        check({name, "_fill_ldata"},  32'(load_data), 32'(oh(e.way)));
        check({name, "_fill_vin"},    32'(valid_in), 32'd1);
        check({name, "_fill_csel"},   32'(cache_in_sel), 32'd0);
        check({name, "_fill_addr"},   32'(mem_address_sel), 32'd0);
        check({name, "_fill_way"},    32'(way_sel), 32'(e.way));
        hit = oh(e.way);
      end
      if (mem_resp) begin
        got_resp = 1'b1;
        if (sb.size() == 0) begin
          check({name, "_sb_depth"}, 32'd0, 32'd1);
        end else begin
          x = sb.pop_front();
          check({name, "_latency"},  32'(cyc), 32'(x.lat));
          check({name, "_way_sel"},  32'(way_sel), 32'(x.way));
          check({name, "_plru_out"}, 32'(plru_out), 32'(x.plru));
          check({name, "_load_plru"}, 32'(load_plru), 32'd1);
          check({name, "_hit_ldata"}, 32'(load_data), x.wr ? 32'(oh(x.way)) : 32'd0);
          check({name, "_hit_ldirty"}, 32'(load_dirty), x.wr ? 32'(oh(x.way)) : 32'd0);
          check({name, "_hit_din"},  32'(dirty_in), 32'(x.wr));
          check({name, "_hit_csel"}, 32'(cache_in_sel), 32'(x.wr));
        end
      end
      @(negedge clk);
    end
    check({name, "_resp_seen"}, 32'(got_resp), 32'd1);
    check({name, "_writeback"}, 32'(saw_wb), 32'(wb));

    s_cyc = 1'b0; s_stb = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    m_ack = 1'b0; m_retry = 1'b0;
    #1;
    check({name, "_idle_resp"}, 32'(mem_resp), 32'd0);
    check({name, "_idle_cyc"},  32'(m_cyc), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    s_cyc = 1'b0; s_stb = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    m_ack = 1'b0; m_retry = 1'b0;
    hit = '0; valid = '0; dirty = '0; plru_in = '0;
    @(negedge clk);
    #1;
    check("rst_resp",  32'(mem_resp), 32'd0);
    check("rst_mcyc",  32'(m_cyc | m_stb), 32'd0);
    check("rst_msel",  32'(m_sel), 32'd0);
    check("rst_loads", 32'(load_data | load_tag | load_valid | load_dirty), 32'd0);
    check("rst_misc",  32'({physical_mem_write, load_plru, way_sel, valid_in,
                            dirty_in, cache_in_sel, mem_address_sel}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_txn(4'b0000, 4'b0000, 3'b000, -1, 1'b1, 1'b0, 0, "cold_rd");
    run_txn(4'b1111, 4'b0000, 3'b000, -1, 1'b1, 1'b0, 0, "full_clean");
    run_txn(4'b1111, 4'b1000, 3'b101, -1, 1'b0, 1'b1, 0, "dirty_wr");
    run_txn(4'b1111, 4'b0000, 3'b010, -1, 1'b1, 1'b0, 1, "fill_retry");
    run_txn(4'b1111, 4'b1111, 3'b110, -1, 1'b1, 1'b0, 1, "wb_retry");
    run_txn(4'b1011, 4'b1111, 3'b111, -1, 1'b0, 1'b1, 0, "low_invalid");
    run_txn(4'b1111, 4'b1111, 3'b001, 2, 1'b1, 1'b1, 0, "rw_both");
    for (int i = 0; i < 4; i++)
      run_txn(4'b1111, 4'b0000, 3'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
              (i % 2) == 0, (i % 2) != 0, 0, "rand_hit");

    // Reset while a writeback is on the bus.
    valid = 4'b1111; dirty = 4'b1000; plru_in = 3'b101; hit = '0;
    s_cyc = 1'b1; s_stb = 1'b1; mem_read = 1'b1; mem_write = 1'b0;
    m_ack = 1'b0; m_retry = 1'b0;
    #1;
    check("rwb_miss_cyc", 32'(m_cyc), 32'd0);
    @(negedge clk);
    #1;
    check("rwb_active", 32'({m_cyc, physical_mem_write}), 32'b11);
    rst_n = 1'b0;
    #1;
    check("rwb_drop_cyc", 32'({m_cyc, m_stb, physical_mem_write}), 32'd0);
    check("rwb_noload",   32'(load_data | load_tag | load_valid | load_dirty), 32'd0);
    s_cyc = 1'b0; s_stb = 1'b0; mem_read = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_hits = 0;
    exp_misses = 0;
    @(negedge clk);

    run_txn(4'b0000, 4'b0000, 3'b000, -1, 1'b1, 1'b0, 0, "post_rst");
    for (int i = 0; i < 5; i++)
      run_txn(4'b1111, 4'b0101, 3'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
              (i % 2) != 0, (i % 2) == 0, 0, "cnt_hit");
    run_txn(4'b1111, 4'b0100, 3'b100, -1, 1'b0, 1'b1, 0, "cnt_miss");

`ifdef CACHE_PERF_CNT_EN
    check("hit_count",  hit_count, 32'(exp_hits));
    check("miss_count", miss_count, 32'(exp_misses));
`endif

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cache_ctrl_nway.md
# cache_ctrl_nway

Parametrised N-way set-associative cache controller, successor of the 2-way controller. Sits between the CPU-side slave bus (s_cyc/s_stb) and the physical-memory master bus (m_cyc/m_stb/m_ack/m_retry), and drives the load/select lines of an external tag/data/valid/dirty datapath. Adds tree-PLRU victim selection, write-allocate on write miss, a registered victim way, and proper retry back-off.

## Interface
- WAYS, 4, associativity; power of two, 2..8
- WIDX, $clog2(WAYS), way index width (derived, do not override)
- SEL_W, 16, memory byte-select width

- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- s_cyc, s_stb  in  1  CPU request qualifiers
- mem_read, mem_write  in  1  CPU request type
- mem_resp  out  1  CPU acknowledge (one cycle per request)
- m_cyc, m_stb  out  1  memory bus cycle/strobe
- physical_mem_write  out  1  memory write enable
- m_sel  out  SEL_W  byte selects; all-ones whenever m_stb=1, else 0
- m_ack, m_retry  in  1  memory acknowledge / retry
- hit  in  WAYS  per-way tag-match-and-valid for current set
- valid, dirty  in  WAYS  per-way valid/dirty bits of current set
- plru_in  in  WAYS-1  tree-PLRU bits of current set
- plru_out  out  WAYS-1  updated PLRU bits; load_plru  out  1  write enable
- way_sel  out  WIDX  datapath output-mux way select
- load_data, load_tag, load_valid, load_dirty  out  WAYS  one-hot array write enables
- valid_in, dirty_in  out  1  bit values written with load_valid/load_dirty
- cache_in_sel  out  1  0=fill data from memory, 1=CPU write data
- mem_address_sel  out  1  0=CPU address, 1=victim tag + set address

## Operation
- States: COMPARE, WRITEBACK, FILL, BACKOFF. BACKOFF holds a 1-bit return register (WRITEBACK or FILL).
- req = s_cyc & s_stb & (mem_read | mem_write). Both read and write set: treated as read.
- COMPARE, req & hit[w] (at most one bit set; multiple hits are illegal and unchecked): way_sel=w, mem_resp=1, load_plru=1, plru_out=plru_in with path to w updated. Write hit additionally: load_data[w]=1, cache_in_sel=1, load_dirty[w]=1, dirty_in=1.
- COMPARE, req & miss: victim = lowest-index way with valid=0; if all ways valid, PLRU victim. Victim registered into victim_q on this edge. Go to WRITEBACK if the chosen victim's valid & dirty bits are both set, else FILL. No datapath loads on the miss cycle.
- Tree PLRU: node i has children 2i+1 (bit=0) and 2i+2 (bit=1). Victim walk: from root follow the child selected by the bit. Access to way w: every node on w's path is set to point to the sibling subtree not containing w.
- WRITEBACK: way_sel=victim_q, mem_address_sel=1, physical_mem_write=1, m_cyc=m_stb=1. On m_ack & !m_retry: load_dirty[victim_q]=1, dirty_in=0, then go to FILL.
- FILL: way_sel=victim_q, m_cyc=m_stb=1, physical_mem_write=0. On m_ack & !m_retry: load_data/load_tag/load_valid[victim_q]=1, valid_in=1, cache_in_sel=0, then go to COMPARE. The request then hits and is serviced by the normal hit path, so writes are write-allocate.
- m_retry=1 in WRITEBACK/FILL (with or without ack): no loads; go to BACKOFF. BACKOFF drives m_cyc=m_stb=0 for exactly one cycle, then returns to the saved state.
- Any output not named above is 0 in every state.

## Timing
- Reset (asynchronous, immediate): state=COMPARE, victim_q=0, return register=WRITEBACK. Every output is 0 until a request appears. Reset during WRITEBACK/FILL drops m_cyc/m_stb in the same cycle with no partial loads.
- Hit: mem_resp is combinational in the same cycle as req.
- Clean miss: miss cycle, then ≥1 FILL cycle ending with ack, then mem_resp in the COMPARE cycle. Zero-wait memory gives mem_resp on cycle 3.
- Dirty miss: miss cycle, WRITEBACK, FILL, then COMPARE. Zero-wait memory gives mem_resp on cycle 4.
- Each retry adds 2 cycles (retry cycle plus BACKOFF).
- req deasserted during WRITEBACK/FILL: the transaction still completes, then the controller returns to COMPARE idle.

## Configuration
- CACHE_PERF_CNT_EN defined: adds output ports hit_count and miss_count (32 bits each).
  - hit_count increments on each hit mem_resp; miss_count increments on each miss detection in COMPARE.
  - Both saturate at 0xFFFFFFFF and reset to 0.
- Undefined: the ports and counters do not exist; behaviour is otherwise identical.

## Test plan
- WAYS=4, all invalid, read addr A → victim way 0 filled (load_valid[0], valid_in=1); mem_resp on cycle 3; plru_out=3'b011.
- Set full and clean, plru_in=3'b000, read miss → victim way 0, no WRITEBACK, FILL only.
- Set full, plru_in=3'b101 (victim way 3), dirty[3]=1, write miss → WRITEBACK with m_sel=16'hFFFF, physical_mem_write=1; FILL; then write hit sets load_dirty[3] with dirty_in=1.
- m_retry on first FILL ack → one BACKOFF cycle with m_stb=0, FILL re-issued, completes on second ack; no loads during the retry.
- rst_n low mid-WRITEBACK → m_cyc=0 immediately; after release state=COMPARE and next read miss behaves normally.
- With CACHE_PERF_CNT_EN defined, 5 hits + 2 misses → hit_count=7 (5 plus the 2 post-fill hits) and miss_count=2.
